// File: rtl/cnn_window_reader.sv
// Read-side address sequencer: walks a KxK window with stride over an HxW
// raster-ordered feature-map buffer, one address per valid/ready transfer.
module cnn_window_reader #(
  parameter int width_p      = 8,
  parameter int height_p     = 8,
  parameter int kernel_p     = 3,
  parameter int stride_p     = 1,
  parameter int addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [addr_width_p-1:0]     addr_o,
  output logic [$clog2(kernel_p):0]   kx_o,
  output logic [$clog2(kernel_p):0]   ky_o,
  output logic [$clog2(width_p):0]    ox_o,
  output logic [$clog2(height_p):0]   oy_o,
  output logic                        first_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        frame_done_o
);

  localparam int ow_lp = (width_p - kernel_p) / stride_p + 1;
  localparam int oh_lp = (height_p - kernel_p) / stride_p + 1;
  localparam int kw_lp = $clog2(kernel_p) + 1;
  localparam int xw_lp = $clog2(width_p) + 1;
  localparam int yw_lp = $clog2(height_p) + 1;
  localparam int aw_lp = addr_width_p;

  localparam logic [kw_lp-1:0] k_last_lp  = kw_lp'(kernel_p - 1);
  localparam logic [xw_lp-1:0] ox_last_lp = xw_lp'(ow_lp - 1);
  localparam logic [yw_lp-1:0] oy_last_lp = yw_lp'(oh_lp - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [kw_lp-1:0]   kx_reg, kx_next, ky_reg, ky_next;
  logic [xw_lp-1:0]   ox_reg, ox_next;
  logic [yw_lp-1:0]   oy_reg, oy_next;

  logic kx_wrap, ky_wrap, ox_wrap, oy_wrap, frame_end;

  assign kx_wrap   = (kx_reg == k_last_lp);
  assign ky_wrap   = (ky_reg == k_last_lp);
  assign ox_wrap   = (ox_reg == ox_last_lp);
  assign oy_wrap   = (oy_reg == oy_last_lp);
  assign frame_end = kx_wrap && ky_wrap && ox_wrap && oy_wrap;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
      kx_reg    <= '0;
      ky_reg    <= '0;
      ox_reg    <= '0;
      oy_reg    <= '0;
    end else begin
      state_reg <= state_next;
      kx_reg    <= kx_next;
      ky_reg    <= ky_next;
      ox_reg    <= ox_next;
      oy_reg    <= oy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kx_next    = kx_reg;
    ky_next    = ky_reg;
    ox_next    = ox_reg;
    oy_next    = oy_reg;
    case (state_reg)
      IDLE: begin
        if (start_i && !abort_i) state_next = RUN;
      end
      RUN: begin
        // Abort outranks a transfer, including the final one of the frame.
        if (abort_i || (ready_i && frame_end)) begin
          state_next = abort_i ? IDLE : DONE;
          kx_next    = '0;
          ky_next    = '0;
          ox_next    = '0;
          oy_next    = '0;
        end else if (ready_i) begin
          kx_next = kx_wrap ? '0 : kx_reg + kw_lp'(1);
          if (kx_wrap) begin
            ky_next = ky_wrap ? '0 : ky_reg + kw_lp'(1);
            if (ky_wrap) begin
              ox_next = ox_wrap ? '0 : ox_reg + xw_lp'(1);
              if (ox_wrap) oy_next = oy_reg + yw_lp'(1);
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [aw_lp-1:0] row_w, col_w;

  always_comb begin
    row_w  = aw_lp'(oy_reg) * aw_lp'(stride_p) + aw_lp'(ky_reg);
    col_w  = aw_lp'(ox_reg) * aw_lp'(stride_p) + aw_lp'(kx_reg);
    addr_o = row_w * aw_lp'(width_p) + col_w;
  end

  assign valid_o      = (state_reg == RUN);
  assign busy_o       = (state_reg != IDLE);
  assign frame_done_o = (state_reg == DONE);
  assign first_o      = valid_o && (kx_reg == '0) && (ky_reg == '0);
  assign last_o       = valid_o && kx_wrap && ky_wrap;
  assign kx_o         = kx_reg;
  assign ky_o         = ky_reg;
  assign ox_o         = ox_reg;
  assign oy_o         = oy_reg;

endmodule

// File: tb/tb_cnn_window_reader.sv
// Directed bench for cnn_window_reader over four map/kernel/stride configurations.
module tb_cnn_window_reader;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic reset_i, start_i, abort_i, ready_i;

  // u0: 4x4 K2 S2
  logic v0, f0, l0, b0, d0;
  logic [15:0] a0;
  logic [1:0] kx0, ky0;
  logic [2:0] ox0, oy0;
  // u1: defaults 8x8 K3 S1
  logic v1, f1, l1, b1, d1;
  logic [15:0] a1;
  logic [2:0] kx1, ky1;
  logic [3:0] ox1, oy1;
  // u2: 5x4 K2 S2
  logic v2, f2, l2, b2, d2;
  logic [15:0] a2;
  logic [1:0] kx2, ky2;
  logic [3:0] ox2;
  logic [2:0] oy2;
  // u3: 2x2 K1 S1
  logic v3, f3, l3, b3, d3;
  logic [15:0] a3;
  logic [0:0] kx3, ky3;
  logic [1:0] ox3, oy3;

  cnn_window_reader #(.width_p(4), .height_p(4), .kernel_p(2), .stride_p(2), .addr_width_p(16)) u0 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i), .ready_i(ready_i),
    .valid_o(v0), .addr_o(a0), .kx_o(kx0), .ky_o(ky0), .ox_o(ox0), .oy_o(oy0),
    .first_o(f0), .last_o(l0), .busy_o(b0), .frame_done_o(d0));

  cnn_window_reader u1 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i), .ready_i(ready_i),
    .valid_o(v1), .addr_o(a1), .kx_o(kx1), .ky_o(ky1), .ox_o(ox1), .oy_o(oy1),
    .first_o(f1), .last_o(l1), .busy_o(b1), .frame_done_o(d1));

  cnn_window_reader #(.width_p(5), .height_p(4), .kernel_p(2), .stride_p(2), .addr_width_p(16)) u2 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i), .ready_i(ready_i),
    .valid_o(v2), .addr_o(a2), .kx_o(kx2), .ky_o(ky2), .ox_o(ox2), .oy_o(oy2),
    .first_o(f2), .last_o(l2), .busy_o(b2), .frame_done_o(d2));

  cnn_window_reader #(.width_p(2), .height_p(2), .kernel_p(1), .stride_p(1), .addr_width_p(16)) u3 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i), .ready_i(ready_i),
    .valid_o(v3), .addr_o(a3), .kx_o(kx3), .ky_o(ky3), .ox_o(ox3), .oy_o(oy3),
    .first_o(f3), .last_o(l3), .busy_o(b3), .frame_done_o(d3));

  // Observation view of whichever instance the current test targets.
  int sel;
  int obs_addr, obs_kx, obs_ky, obs_ox, obs_oy;
  int obs_valid, obs_first, obs_last, obs_busy, obs_done;

  always_comb begin
    obs_addr = 0; obs_kx = 0; obs_ky = 0; obs_ox = 0; obs_oy = 0;
    obs_valid = 0; obs_first = 0; obs_last = 0; obs_busy = 0; obs_done = 0;
    case (sel)
      0: begin
        obs_addr = int'(a0); obs_kx = int'(kx0); obs_ky = int'(ky0); obs_ox = int'(ox0); obs_oy = int'(oy0);
        obs_valid = int'(v0); obs_first = int'(f0); obs_last = int'(l0); obs_busy = int'(b0); obs_done = int'(d0);
      end
      1: begin
        obs_addr = int'(a1); obs_kx = int'(kx1); obs_ky = int'(ky1); obs_ox = int'(ox1); obs_oy = int'(oy1);
        obs_valid = int'(v1); obs_first = int'(f1); obs_last = int'(l1); obs_busy = int'(b1); obs_done = int'(d1);
      end
      2: begin
        obs_addr = int'(a2); obs_kx = int'(kx2); obs_ky = int'(ky2); obs_ox = int'(ox2); obs_oy = int'(oy2);
        obs_valid = int'(v2); obs_first = int'(f2); obs_last = int'(l2); obs_busy = int'(b2); obs_done = int'(d2);
      end
      default: begin
        obs_addr = int'(a3); obs_kx = int'(kx3); obs_ky = int'(ky3); obs_ox = int'(ox3); obs_oy = int'(oy3);
        obs_valid = int'(v3); obs_first = int'(f3); obs_last = int'(l3); obs_busy = int'(b3); obs_done = int'(d3);
      end
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int addr;
    int first;
    int last;
  } vec_t;

  vec_t tbl[16];
  int   seen_addr[$];
  int   seen_first[$];
  int   seen_last[$];
  int   last_ox, last_oy;
  logic [15:0] lfsr = 16'hACE1;

  function automatic logic pick_ready(input bit bp);
    if (!bp) return 1'b1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    return lfsr[0];
  endfunction

  task automatic do_reset();
    reset_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  // Pulse start, then consume one whole frame, checking each transfer
  // against a nested-loop model and the frame-end handshake afterwards.
  task automatic run_frame(input string tag, input int w, input int k, input int s,
                           input int ow, input int oh, input bit bp, output int done_cyc);
    int cycles, wait_n, bad, stall_addr, stall_kx, exp_addr, n;
    bit stalled;
    seen_addr.delete(); seen_first.delete(); seen_last.delete();
    done_cyc = 0;
    bad = 0; n = 0; stalled = 0;
    @(negedge clk_i); start_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; cycles = 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            exp_addr = (oy * s + ky) * w + ox * s + kx;
            wait_n = 0;
            ready_i = pick_ready(bp);
            while (!(obs_valid == 1 && ready_i)) begin
              if (obs_valid == 1) begin
                stalled = 1; stall_addr = obs_addr; stall_kx = obs_kx;
              end
              wait_n++;
              if (wait_n > 64) begin
                n_checks++;
                $display("FAIL %s timeout: no transfer %0d within 64 cycles, expected addr %0d", tag, n, exp_addr);
                ready_i = 1'b1;
                return;
              end
              @(negedge clk_i); cycles++;
              if (stalled) begin
                check({tag, " hold addr"}, obs_addr, stall_addr);
                check({tag, " hold kx"}, obs_kx, stall_kx);
                stalled = 0;
              end
              ready_i = pick_ready(bp);
            end
            check({tag, " addr"}, obs_addr, exp_addr);
            check({tag, " kx"}, obs_kx, kx);
            check({tag, " ky"}, obs_ky, ky);
            check({tag, " ox"}, obs_ox, ox);
            check({tag, " oy"}, obs_oy, oy);
            check({tag, " first"}, obs_first, int'(kx == 0 && ky == 0));
            check({tag, " last"}, obs_last, int'(kx == k - 1 && ky == k - 1));
            $display("xfer %s #%0d addr=%0d kx=%0d ky=%0d ox=%0d oy=%0d first=%0d last=%0d",
                     tag, n, obs_addr, obs_kx, obs_ky, obs_ox, obs_oy, obs_first, obs_last);
            seen_addr.push_back(obs_addr);
            seen_first.push_back(obs_first);
            seen_last.push_back(obs_last);
            last_ox = obs_ox; last_oy = obs_oy;
            if ((obs_addr % w) > (ow - 1) * s + k - 1) bad++;
            n++;
            @(negedge clk_i); cycles++;
          end
    ready_i = 1'b1;
    done_cyc = cycles;
    check({tag, " frame_done pulse"}, obs_done, 1);
    check({tag, " valid in DONE"}, obs_valid, 0);
    @(negedge clk_i);
    check({tag, " frame_done single"}, obs_done, 0);
    check({tag, " busy after done"}, obs_busy, 0);
    check({tag, " unvisited column"}, bad, 0);
  endtask

  task automatic check_table(input string tag);
    check({tag, " count"}, seen_addr.size(), 16);
    if (seen_addr.size() == 16)
      for (int i = 0; i < 16; i++) begin
        check({tag, " tbl addr"}, seen_addr[i], tbl[i].addr);
        check({tag, " tbl first"}, seen_first[i], tbl[i].first);
        check({tag, " tbl last"}, seen_last[i], tbl[i].last);
      end
  endtask

  // Start a frame on the selected instance and stop with transfer 8 pending.
  task automatic run_to_eighth(input string tag);
    @(negedge clk_i); start_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    check({tag, " addr at xfer 8"}, obs_addr, 7);
  endtask

  initial begin
    int a_list[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int cyc, forbidden;
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr  = a_list[i];
      tbl[i].first = int'((i % 4) == 0);
      tbl[i].last  = int'((i % 4) == 3);
    end
    sel = 0;
    reset_i = 1'b0; start_i = 1'b1; abort_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset valid", obs_valid, 0);
    check("reset busy", obs_busy, 0);
    check("reset done", obs_done, 0);
    check("reset first", obs_first, 0);
    check("reset last", obs_last, 0);
    check("reset addr", obs_addr, 0);

    // 4x4 K2 S2, ready tied high
    do_reset(); sel = 0;
    run_frame("s2", 4, 2, 2, 2, 2, 1'b0, cyc);
    check_table("s2");
    check("s2 latency", cyc, 17);

    // Same frame with pseudo-random backpressure
    do_reset(); sel = 0;
    run_frame("bp", 4, 2, 2, 2, 2, 1'b1, cyc);
    check_table("bp");

    // Defaults 8x8 K3 S1
    do_reset(); sel = 1;
    run_frame("def", 8, 3, 1, 6, 6, 1'b0, cyc);
    check("def count", seen_addr.size(), 324);
    check("def latency", cyc, 325);
    if (seen_addr.size() > 0) check("def final addr", seen_addr[$], 63);
    check("def final ox", last_ox, 5);
    check("def final oy", last_oy, 5);

    // 5x4 K2 S2: column 4 never visited
    do_reset(); sel = 2;
    run_frame("w5", 5, 2, 2, 2, 2, 1'b0, cyc);
    check("w5 count", seen_addr.size(), 16);
    forbidden = 0;
    foreach (seen_addr[i])
      if (seen_addr[i] == 4 || seen_addr[i] == 9 || seen_addr[i] == 14 || seen_addr[i] == 19)
        forbidden++;
    check("w5 forbidden addrs", forbidden, 0);

    // Abort after transfer 7, then restart
    do_reset(); sel = 0;
    run_to_eighth("abort");
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort valid", obs_valid, 0);
    check("abort busy", obs_busy, 0);
    check("abort done", obs_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("abort no done", obs_done, 0);
    end
    run_frame("restart", 4, 2, 2, 2, 2, 1'b0, cyc);
    check_table("restart");

    // Reset mid-frame
    do_reset(); sel = 0;
    run_to_eighth("rst");
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst valid", obs_valid, 0);
    check("rst busy", obs_busy, 0);
    check("rst done", obs_done, 0);
    check("rst first", obs_first, 0);
    check("rst last", obs_last, 0);
    check("rst addr", obs_addr, 0);
    check("rst ox", obs_ox, 0);
    reset_i = 1'b1;

    // Abort in IDLE overrides start
    @(negedge clk_i); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; abort_i = 1'b0;
    check("idle abort busy", obs_busy, 0);

    // 2x2 K1 with start held high: back-to-back frames through IDLE
    do_reset(); sel = 3;
    @(negedge clk_i); start_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("k1 valid", obs_valid, 1);
      check("k1 addr", obs_addr, i);
      check("k1 first", obs_first, 1);
      check("k1 last", obs_last, 1);
      $display("xfer k1 #%0d addr=%0d first=%0d last=%0d", i, obs_addr, obs_first, obs_last);
    end
    @(negedge clk_i);
    check("k1 done", obs_done, 1);
    check("k1 done valid", obs_valid, 0);
    @(negedge clk_i);
    check("k1 idle busy", obs_busy, 0);
    check("k1 idle valid", obs_valid, 0);
    @(negedge clk_i);
    check("k1 restart valid", obs_valid, 1);
    check("k1 restart addr", obs_addr, 0);
    start_i = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
